// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the IF stage, the fetch queue and ID.
// The master side is the IF/ID environment and the slave side is the queue.
// The DEPTH parameter must match the attached fetch_queue so that count lines up.
interface fetch_queue_if #(
    parameter int DEPTH = 2
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [4:0]    out_exccode;
    logic          out_bd;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_exccode, out_bd, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_exccode, out_bd, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {PC, instruction} pairs between IF and ID.
// Illegal fetch addresses are tagged with an AdEL ExcCode at enqueue time and
// the instruction word is replaced by a nop. in_ready feeds the PC enable.
// Optional macro FETCH_QUEUE_BD_TRACK_EN adds per-entry branch-delay-slot tracking;
// without it out_bd is tied to 0.
module fetch_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] PC_LO     = 32'h0000_3000,
    parameter logic [31:0] PC_HI     = 32'h0000_6FFC,
    parameter logic [4:0]  ADEL_CODE = 5'd4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];
    logic [4:0]    exc_mem_r   [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          enq_s;
    logic          deq_s;
    logic          bad_addr_s;
    logic [31:0]   st_instr_s;
    logic [4:0]    st_exc_s;

`ifdef FETCH_QUEUE_BD_TRACK_EN
    logic          bd_mem_r [DEPTH];
    logic          prev_branch_r;

    // True for every jump/branch whose following instruction sits in a delay slot.
    function automatic logic is_branch(input logic [31:0] instr);
        logic res;
        case (instr[31:26])
            6'b000001, 6'b000010, 6'b000011, 6'b000100,
            6'b000101, 6'b000110, 6'b000111: res = 1'b1;
            6'b000000: res = (instr[5:0] == 6'b001000) || (instr[5:0] == 6'b001001);
            default:   res = 1'b0;
        endcase
        return res;
    endfunction
`endif

    // Handshake qualification; flush suppresses both sides of the transfer.
    assign q.in_ready  = (count_r != CW'(DEPTH));
    assign q.out_valid = (count_r != {CW{1'b0}});
    assign enq_s       = q.in_valid & q.in_ready & ~q.flush;
    assign deq_s       = q.out_valid & q.out_ready & ~q.flush;
    assign q.count     = count_r;

    // Head entry is presented straight from storage; stale when empty.
    assign q.out_pc      = pc_mem_r[rd_ptr_r];
    assign q.out_instr   = instr_mem_r[rd_ptr_r];
    assign q.out_exccode = exc_mem_r[rd_ptr_r];
`ifdef FETCH_QUEUE_BD_TRACK_EN
    assign q.out_bd      = bd_mem_r[rd_ptr_r];
`else
    assign q.out_bd      = 1'b0;
`endif

    // Address legality check and the values written into the new entry.
    always_comb begin
        bad_addr_s = (q.in_pc[1:0] != 2'b00) || (q.in_pc < PC_LO) || (q.in_pc > PC_HI);
        st_instr_s = q.in_instr;
        st_exc_s   = 5'd0;
        if (bad_addr_s) begin
            st_instr_s = 32'h0000_0000;
            st_exc_s   = ADEL_CODE;
        end else begin
            st_instr_s = q.in_instr;
            st_exc_s   = 5'd0;
        end
    end

    // Pointer and occupancy bookkeeping: reset, then flush, then enq/deq.
    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: cleared on reset, written at wr_ptr on enqueue, kept on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
                exc_mem_r[i]   <= 5'd0;
            end
        end else if (enq_s) begin
            pc_mem_r[wr_ptr_r]    <= q.in_pc;
            instr_mem_r[wr_ptr_r] <= st_instr_s;
            exc_mem_r[wr_ptr_r]   <= st_exc_s;
        end
    end

`ifdef FETCH_QUEUE_BD_TRACK_EN
    // Delay-slot tracking: each entry inherits whether its predecessor was a branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_branch_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bd_mem_r[i] <= 1'b0;
            end
        end else if (q.flush) begin
            prev_branch_r <= 1'b0;
        end else if (enq_s) begin
            bd_mem_r[wr_ptr_r] <= prev_branch_r;
            prev_branch_r      <= is_branch(st_instr_s);
        end
    end
`endif
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer side of the program counter: buffers {PC, instruction} pairs produced by the IF stage and delivers them to ID.
- Uses a valid/ready handshake. in_ready drives the PC register's enable, so a full queue freezes fetch.
- Flags instruction-fetch address errors (AdEL) at enqueue time so the exception travels with the instruction.
- A single-cycle flush from the exception/redirect logic discards all buffered fetches.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- PC_LO, 32'h0000_3000, lowest legal fetch address.
- PC_HI, 32'h0000_6FFC, highest legal fetch address.
- ADEL_CODE, 5'd4, ExcCode reported for an illegal fetch address.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- flush  input  1  discard all entries this cycle.
- in_valid  input  1  IF presents a fetch.
- in_ready  output  1  queue can accept; connects to the PC enable.
- in_pc  input  32  fetch address.
- in_instr  input  32  word read from instruction memory at in_pc.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  ID accepts the head (low = stall).
- out_pc  output  32  head PC.
- out_instr  output  32  head instruction.
- out_exccode  output  5  head ExcCode; 0 = none.
- out_bd  output  1  head is in a branch delay slot (see Optional Feature).
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Storage:
  - Circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count register ranges 0..DEPTH.
- Reset:
  - count=0, both pointers=0, every entry cleared to zero.
  - Resulting outputs: out_valid=0, out_pc=0, out_instr=0, out_exccode=0, out_bd=0, in_ready=1.
- in_ready = (count != DEPTH).
  - Registered-state function only; no combinational path from out_ready.
- out_valid = (count != 0).
  - out_pc, out_instr, out_exccode and out_bd are read combinationally from entry[rd_ptr].
  - When the queue is empty these outputs hold stale data; consumers qualify them with out_valid.
- Enqueue (enq = in_valid & in_ready & ~flush):
  - Write entry[wr_ptr] and increment wr_ptr.
  - Latency: an enqueue into an empty queue appears at the outputs on the next cycle.
- Address check at enqueue:
  - Bad if in_pc[1:0] != 0, in_pc < PC_LO, or in_pc > PC_HI (unsigned compares).
  - Bad address: store exccode=ADEL_CODE and instr=32'h0000_0000 (nop); in_pc is stored unchanged.
  - Good address: store exccode=0 and instr=in_instr.
- Dequeue (deq = out_valid & out_ready & ~flush): increment rd_ptr.
- Count update:
  - enq without deq: +1.
  - deq without enq: -1.
  - both or neither: unchanged.
  - Simultaneous enq and deq is legal at any count < DEPTH; when full, in_ready=0, so only deq occurs.
- Flush:
  - Next cycle: count=0 and both pointers=0.
  - Any enqueue or dequeue in the same cycle is dropped.
  - Entry contents are not cleared.
- Priority: reset > flush > enq/deq.
- Reset asserted mid-stream: all state returns to reset values at the next edge, regardless of in_valid, out_ready or flush.
- No overflow or underflow is possible: writes are gated by in_ready and reads by out_valid.

Optional Feature:
- Macro: FETCH_QUEUE_BD_TRACK_EN.
- Defined:
  - Each entry carries a bd bit, set to the value of register prev_branch at enqueue.
  - prev_branch updates on every enqueue. It is 1 if the stored instr is one of:
    - opcode 6'b000001 (REGIMM), 000010 (j), 000011 (jal), 000100 (beq), 000101 (bne), 000110 (blez), 000111 (bgtz).
    - opcode 0 with funct 6'b001000 (jr) or 6'b001001 (jalr).
  - Otherwise prev_branch is 0. An AdEL entry stores a nop, so it clears prev_branch.
  - prev_branch is cleared by reset and by flush.
  - out_bd = entry[rd_ptr].bd.
- Not defined: no bd storage and no prev_branch register; out_bd is tied to 0.

Test Plan:
- Reset then enqueue pc=0x3000, instr=0x2408_0001; out_ready=0 → next cycle out_valid=1, out_pc=0x3000, out_instr=0x2408_0001, out_exccode=0, count=1.
- Enqueue 0x3000 and 0x3004 with out_ready=0 → count=2, in_ready=0; a third offer at 0x3008 is not accepted. Set out_ready=1 → heads 0x3000 then 0x3004 appear in order, and 0x3008 is accepted once count<2.
- Enqueue pc=0x3002, then pc=0x2FFC, then pc=0x7000 → each entry shows out_exccode=4 and out_instr=0 with its pc preserved.
- Hold count=1, in_valid=1, out_ready=1 for 8 cycles → count stays 1, pointers wrap, PCs emerge in order with 1-cycle latency.
- With count=2, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, in_ready=1, and no entry from that cycle survives.
- With the macro defined: enqueue beq (0x1000_0003) at 0x3000, then addu at 0x3004 → second entry out_bd=1, first out_bd=0. A flush between the two makes the second entry out_bd=0. Without the macro, out_bd=0 throughout.
